lcd_rgb_rx: RTL and testbench

- Receiving end of the parallel RGB565 LCD interface: samples de/hs/vs/rgb and recovers a pixel stream with x/y coordinates and frame/line markers.
- Measures active width and height per frame and reports lock and error status.
- Sits behind a camera or loopback port, with clk = incoming pixel clock; feeds frame buffers or checkers in the same style as the existing lcd_disp pixel_xpos/pixel_ypos consumers.

---
 rtl/lcd_rgb_rx.sv | 195 +++++++++++++++++++
 tb/tb_lcd_rgb_rx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_rgb_rx.sv
// Parallel RGB565 LCD receiver: recovers pixels with x/y, measures frame size, reports lock/errors.
// Optional per-frame CRC-16-CCITT over received pixels is enabled by defining LCD_RGB_RX_CRC_EN.
module lcd_rgb_rx #(
   parameter int DATA_W = 16,
   parameter int POS_W  = 11,
   parameter bit VS_POL = 1'b0,
   parameter bit HS_POL = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lcd_de,
   input  logic              lcd_hs,
   input  logic              lcd_vs,
   input  logic [DATA_W-1:0] lcd_rgb_data,
   output logic              pix_valid,
   output logic [DATA_W-1:0] pix_data,
   output logic [POS_W-1:0]  pix_x,
   output logic [POS_W-1:0]  pix_y,
   output logic              pix_sof,
   output logic              pix_eol,
   output logic              frame_done,
   output logic [POS_W-1:0]  frame_width,
   output logic [POS_W-1:0]  frame_height,
   output logic [15:0]       frame_crc,
   output logic              locked,
   output logic              err_width,
   output logic              err_ovf,
   output logic              hs_seen
);

   localparam logic [POS_W-1:0] POS_MAX = '1;
   localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

   typedef enum logic [1:0] {IDLE, WAIT_LINE, LINE} state_t;

   state_t            state;
   logic              de_r, de_prev, hs_r, hs_prev, vs_r, vs_prev;
   logic [DATA_W-1:0] rgb_r;
   logic [POS_W-1:0]  x_cnt, y_cnt, ref_width, x_now;
   logic              prev_ok;
   logic              vs_start, hs_edge, de_rise, in_frame;
   logic              pixel, line_end, x_sat, y_sat, width_bad;
   logic              frame_end, frame_clean, frame_ok;

   // Syncs reset to their inactive level so a held-idle input never looks like an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         de_r    <= 1'b0;
         de_prev <= 1'b0;
         hs_r    <= ~HS_POL;
         hs_prev <= ~HS_POL;
         vs_r    <= ~VS_POL;
         vs_prev <= ~VS_POL;
         rgb_r   <= '0;
      end else begin
         de_r    <= lcd_de;
         de_prev <= de_r;
         hs_r    <= lcd_hs;
         hs_prev <= hs_r;
         vs_r    <= lcd_vs;
         vs_prev <= vs_r;
         rgb_r   <= lcd_rgb_data;
      end
   end

   assign vs_start = (vs_r == VS_POL) && (vs_prev != VS_POL);
   assign hs_edge  = (hs_r == HS_POL) && (hs_prev != HS_POL);
   assign de_rise  = de_r && !de_prev;
   assign in_frame = (state != IDLE);

   // A frame start overrides everything in the same cycle: the pixel and any line end are dropped.
   assign pixel     = !vs_start && (((state == WAIT_LINE) && de_rise) || ((state == LINE) && de_r));
   assign line_end  = !vs_start && (state == LINE) && !de_r;
   assign x_now     = (state == LINE) ? x_cnt : '0;
   assign x_sat     = pixel && (x_now == POS_MAX);
   assign y_sat     = line_end && (y_cnt == POS_MAX);
   assign width_bad = line_end && (y_cnt != '0) && (x_cnt != ref_width);

   assign frame_end   = vs_start && in_frame && (y_cnt != '0);
   assign frame_clean = !err_width && !err_ovf;
   assign frame_ok    = frame_clean && prev_ok &&
                        (ref_width == frame_width) && (y_cnt == frame_height);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         x_cnt        <= '0;
         y_cnt        <= '0;
         ref_width    <= '0;
         prev_ok      <= 1'b0;
         pix_valid    <= 1'b0;
         pix_data     <= '0;
         pix_x        <= '0;
         pix_y        <= '0;
         pix_sof      <= 1'b0;
         pix_eol      <= 1'b0;
         frame_done   <= 1'b0;
         frame_width  <= '0;
         frame_height <= '0;
         locked       <= 1'b0;
         err_width    <= 1'b0;
         err_ovf      <= 1'b0;
         hs_seen      <= 1'b0;
      end else begin
         pix_valid  <= pixel;
         pix_sof    <= pixel && (x_now == '0) && (y_cnt == '0);
         pix_eol    <= pixel && !lcd_de;
         frame_done <= frame_end;
         if (pixel) begin
            pix_data <= rgb_r;
            pix_x    <= x_now;
            pix_y    <= y_cnt;
         end

         // Status flags stay visible through the frame_done cycle and clear right after it.
         err_width <= (err_width && !frame_done) || width_bad;
         err_ovf   <= (err_ovf && !frame_done) || x_sat || y_sat;
         hs_seen   <= (hs_seen && !frame_done) || hs_edge;

         if (frame_end) begin
            frame_width  <= ref_width;
            frame_height <= y_cnt;
            locked       <= frame_ok;
            prev_ok      <= frame_clean;
         end

         case (state)
            IDLE: begin
               if (vs_start) begin
                  state <= WAIT_LINE;
                  y_cnt <= '0;
               end
            end
            WAIT_LINE: begin
               if (vs_start) begin
                  y_cnt <= '0;
               end else if (de_rise) begin
                  state <= LINE;
                  x_cnt <= POS_ONE;
               end
            end
            LINE: begin
               if (vs_start) begin
                  state <= WAIT_LINE;
                  y_cnt <= '0;
               end else if (de_r) begin
                  if (!x_sat) x_cnt <= x_cnt + POS_ONE;
               end else begin
                  if (y_cnt == '0) ref_width <= x_cnt;
                  if (!y_sat) y_cnt <= y_cnt + POS_ONE;
                  state <= WAIT_LINE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef LCD_RGB_RX_CRC_EN
   logic [15:0] crc;
   logic [15:0] crc_in;
   logic [15:0] crc_upd;

   function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [15:0] d);
      logic [15:0] c;
      logic        fb;
      c = c_in;
      for (int i = 15; i >= 0; i--) begin
         fb = c[15] ^ d[i];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ 16'h1021;
      end
      return c;
   endfunction

   assign crc_in  = 16'(pix_data);
   assign crc_upd = pix_valid ? crc_step(crc, crc_in) : crc;

   // Latched on the same edge frame_done rises, so frame_crc is valid alongside the pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc       <= 16'hFFFF;
         frame_crc <= '0;
      end else if (frame_end) begin
         frame_crc <= crc_upd;
         crc       <= 16'hFFFF;
      end else begin
         crc <= crc_upd;
      end
   end
`else
   assign frame_crc = '0;
`endif

endmodule

// File: tb/tb_lcd_rgb_rx.sv
// Self-checking bench for lcd_rgb_rx: pixel scoreboard plus a table of frames checked at frame_done.
module tb_lcd_rgb_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic        lcd_de, lcd_hs, lcd_vs;
   logic [15:0] lcd_rgb_data;
   logic        pix_valid, pix_sof, pix_eol, frame_done, locked, err_width, err_ovf, hs_seen;
   logic [15:0] pix_data, frame_crc;
   logic [10:0] pix_x, pix_y, frame_width, frame_height;

   lcd_rgb_rx dut (
      .clk(clk), .rst(rst),
      .lcd_de(lcd_de), .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_rgb_data(lcd_rgb_data),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
      .pix_sof(pix_sof), .pix_eol(pix_eol), .frame_done(frame_done),
      .frame_width(frame_width), .frame_height(frame_height), .frame_crc(frame_crc),
      .locked(locked), .err_width(err_width), .err_ovf(err_ovf), .hs_seen(hs_seen)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] data;
      logic [10:0] x;
      logic [10:0] y;
      logic        sof;
      logic        eol;
   } pix_exp_t;

   typedef struct packed {
      logic [10:0] w;
      logic [10:0] h;
      logic        err_w;
      logic        err_o;
      logic        lk;
      logic        hs;
      logic [15:0] crc;
   } done_rec_t;

   typedef struct {
      int lines;
      int width;
      int bad_line;
      int bad_width;
      int exp_w;
      int exp_h;
      bit exp_err;
      bit exp_locked;
   } frame_vec_t;

   pix_exp_t  exp_q[$];
   done_rec_t done_q[$];
   pix_exp_t  mon_e;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int valid_count = 0;
   int sof_count = 0;
   int first_de_cyc = -1;
   int first_valid_cyc = -1;
   int model_x = 0;
   int model_y = 0;

   always @(posedge clk) cyc++;

   // Monitor: every output pixel is popped against the scoreboard; frame_done snapshots are queued.
   always @(negedge clk) begin
      if (!rst) begin
         if (pix_valid) begin
            valid_count++;
            if (pix_sof) sof_count++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_pixel: got pix_valid at x=%0d y=%0d, required no pixel", pix_x, pix_y);
            end else begin
               mon_e = exp_q.pop_front();
               if ({pix_data, pix_x, pix_y, pix_sof, pix_eol} !== mon_e) begin
                  errors++;
                  $display("[TB] FAIL pixel: got data=%h x=%0d y=%0d sof=%b eol=%b, required data=%h x=%0d y=%0d sof=%b eol=%b",
                           pix_data, pix_x, pix_y, pix_sof, pix_eol, mon_e.data, mon_e.x, mon_e.y, mon_e.sof, mon_e.eol);
               end
            end
         end
         if (frame_done)
            done_q.push_back('{frame_width, frame_height, err_width, err_ovf, locked, hs_seen, frame_crc});
      end
   end

   task automatic checkVal(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic send_pixel(input logic [15:0] d, input bit push, input bit last);
      @(negedge clk);
      lcd_de       = 1'b1;
      lcd_rgb_data = d;
      if (push) begin
         if (first_de_cyc < 0) first_de_cyc = cyc;
         exp_q.push_back('{d, 11'(model_x), 11'(model_y), (model_x == 0 && model_y == 0), last});
      end
      model_x++;
   endtask

   task automatic line_gap(input bit push);
      @(negedge clk);
      lcd_de = 1'b0;
      repeat (2) @(negedge clk);
      if (push) model_y++;
   endtask

   task automatic hs_pulse();
      @(negedge clk); lcd_hs = 1'b0;
      @(negedge clk); lcd_hs = 1'b1;
   endtask

   task automatic send_line(input int width, input bit push);
      hs_pulse();
      model_x = 0;
      for (int i = 0; i < width; i++) send_pixel(16'($urandom), push, i == width - 1);
      line_gap(push);
   endtask

   task automatic send_vs();
      @(negedge clk); lcd_vs = 1'b0;
      repeat (2) @(negedge clk);
      lcd_vs  = 1'b1;
      model_y = 0;
   endtask

   task automatic applyStimulus(input frame_vec_t v);
      for (int l = 0; l < v.lines; l++)
         send_line((l == v.bad_line) ? v.bad_width : v.width, 1'b1);
   endtask

   task automatic checkOutput(input string name, input int ew, input int eh, input bit eerr,
                              input bit elock, input bit chk_crc, input logic [15:0] ecrc);
      done_rec_t r;
      int waited = 0;
      while (done_q.size() == 0 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (done_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL %s_done_timeout: got no frame_done in 40 cycles, required one", name);
         return;
      end
      r = done_q.pop_front();
      checkVal({name, "_width"}, r.w, ew);
      checkVal({name, "_height"}, r.h, eh);
      checkVal({name, "_err_width"}, r.err_w, eerr);
      checkVal({name, "_err_ovf"}, r.err_o, 0);
      checkVal({name, "_locked"}, r.lk, elock);
      checkVal({name, "_hs_seen"}, r.hs, 1);
      if (chk_crc) begin
`ifdef LCD_RGB_RX_CRC_EN
         checkVal({name, "_crc"}, r.crc, ecrc);
`else
         checkVal({name, "_crc"}, r.crc, 0);
`endif
      end
   endtask

   task automatic check_all_zero(input string name);
      checkVal({name, "_pix_valid"}, pix_valid, 0);
      checkVal({name, "_pix_data"}, pix_data, 0);
      checkVal({name, "_pix_x"}, pix_x, 0);
      checkVal({name, "_pix_y"}, pix_y, 0);
      checkVal({name, "_sof_eol"}, {pix_sof, pix_eol}, 0);
      checkVal({name, "_frame_done"}, frame_done, 0);
      checkVal({name, "_frame_width"}, frame_width, 0);
      checkVal({name, "_frame_height"}, frame_height, 0);
      checkVal({name, "_frame_crc"}, frame_crc, 0);
      checkVal({name, "_status"}, {locked, err_width, err_ovf, hs_seen}, 0);
   endtask

   // Byte-serial CRC-16-CCITT reference (init 0xFFFF), each 16-bit word fed high byte first.
   function automatic logic [15:0] crc_model(input logic [15:0] w0, input logic [15:0] w1,
                                             input logic [15:0] w2, input logic [15:0] w3);
      logic [15:0] words[4];
      logic [15:0] c;
      logic [7:0]  b;
      words = '{w0, w1, w2, w3};
      c = 16'hFFFF;
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 2; k++) begin
            b = (k == 0) ? words[i][15:8] : words[i][7:0];
            c = c ^ {b, 8'h00};
            for (int j = 0; j < 8; j++)
               c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
         end
      end
      return c;
   endfunction

   initial begin
      #100000;
      errors++;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      frame_vec_t vecs[5];
      vecs[0] = '{4, 8, -1, 0, 8, 4, 1'b0, 1'b0};
      vecs[1] = '{4, 8, -1, 0, 8, 4, 1'b0, 1'b1};
      vecs[2] = '{4, 8,  2, 7, 8, 4, 1'b1, 1'b0};
      vecs[3] = '{4, 8, -1, 0, 8, 4, 1'b0, 1'b0};
      vecs[4] = '{4, 8, -1, 0, 8, 4, 1'b0, 1'b1};

      rst = 1'b1; lcd_de = 1'b0; lcd_hs = 1'b1; lcd_vs = 1'b1; lcd_rgb_data = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      $display("[TB] de activity before first vs");
      send_line(8, 1'b0);
      send_line(8, 1'b0);
      repeat (4) @(negedge clk);
      checkVal("no_pixel_before_vs", valid_count, 0);
      checkVal("no_done_before_vs", done_q.size(), 0);

      $display("[TB] frame table");
      send_vs();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i]);
         send_vs();
         checkOutput($sformatf("frame%0d", i), vecs[i].exp_w, vecs[i].exp_h,
                     vecs[i].exp_err, vecs[i].exp_locked, 1'b0, 16'h0);
         if (i == 0) checkVal("first_pixel_latency", first_valid_cyc - first_de_cyc, 2);
      end
      checkVal("sof_per_frame", sof_count, 5);

      $display("[TB] reset in the middle of line 2");
      send_line(8, 1'b1);
      send_line(8, 1'b1);
      model_x = 0;
      for (int i = 0; i < 4; i++) send_pixel(16'($urandom), 1'b1, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      lcd_de = 1'b0;
      #1 check_all_zero("async_reset");
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      valid_count = 0;
      send_line(8, 1'b0);
      send_line(8, 1'b0);
      repeat (4) @(negedge clk);
      checkVal("no_pixel_after_reset", valid_count, 0);
      checkVal("no_done_after_reset", done_q.size(), 0);
      send_vs();
      applyStimulus(vecs[0]);
      send_vs();
      checkOutput("post_reset", 8, 4, 1'b0, 1'b0, 1'b0, 16'h0);

      $display("[TB] vs during an active partial line");
      send_line(8, 1'b1);
      send_line(8, 1'b1);
      model_x = 0;
      for (int i = 0; i < 4; i++) send_pixel(16'($urandom), 1'b1, 1'b0);
      @(negedge clk); lcd_rgb_data = 16'($urandom); lcd_vs = 1'b0;
      @(negedge clk); lcd_rgb_data = 16'($urandom);
      @(negedge clk); lcd_de = 1'b0; lcd_vs = 1'b1;
      model_y = 0;
      checkOutput("partial", 8, 2, 1'b0, 1'b0, 1'b0, 16'h0);

      $display("[TB] 4x1 frame with fixed pixels for frame_crc");
      hs_pulse();
      model_x = 0;
      send_pixel(16'h0000, 1'b1, 1'b0);
      send_pixel(16'hFFFF, 1'b1, 1'b0);
      send_pixel(16'h1234, 1'b1, 1'b0);
      send_pixel(16'hF800, 1'b1, 1'b1);
      line_gap(1'b1);
      send_vs();
      checkOutput("crc_frame", 4, 1, 1'b0, 1'b0, 1'b1,
                  crc_model(16'h0000, 16'hFFFF, 16'h1234, 16'hF800));

      repeat (4) @(negedge clk);
      checkVal("pixel_queue_drained", exp_q.size(), 0);
      checkVal("done_queue_drained", done_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
